// File: rtl/ram1_ctrl_pkg.sv
// Shared definitions for the single-port RAM controller: FSM states,
// enable levels and the idle bus word.
package ram1_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        RMW_RD,
        RMW_WR,
        DONE
    } state_t;

    localparam logic RamChipEnable  = 1'b1;
    localparam logic RamChipDisable = 1'b0;
    localparam logic ReadEnable     = 1'b1;
    localparam logic ReadDisable    = 1'b0;
    localparam logic WriteEnable    = 1'b1;
    localparam logic WriteDisable   = 1'b0;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;
    localparam logic [3:0]  SelAll   = 4'b1111;
    localparam logic [3:0]  SelNone  = 4'b0000;

    // RAM is word addressed; the CPU byte address loses its two low bits.
    function automatic logic [31:0] word_addr(input logic [29:0] word);
        return {2'b00, word};
    endfunction

endpackage

// File: rtl/ram1_ctrl_byte_merge.sv
// Per-byte-lane merge of a new write word into the word read back from RAM.
module byte_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] new_word,
    input  logic [3:0]  sel,
    output logic [31:0] merged_word
);

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign merged_word[8*gi +: 8] = sel[gi] ? new_word[8*gi +: 8] : old_word[8*gi +: 8];
    end

endmodule

// File: rtl/ram1_ctrl.sv
// CPU-to-asynchronous-RAM access controller: each read or write phase holds
// the RAM strobes for WAIT_CYCLES cycles; partial writes use read-modify-write.
module ram1_ctrl
    import ram1_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [3:0]  cpu_sel,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_stall,
    output logic        ram_ce,
    output logic        ram_re,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    localparam logic [3:0] CntLoad = 4'(WAIT_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [29:0] word_reg;
    logic [3:0]  sel_reg;
    logic [31:0] wdata_reg;
    logic [31:0] merge_reg;
    logic [31:0] rdata_reg;
    logic [31:0] merged_word;
    logic        phase_last;
    logic        addr_lsb_unused;

    assign phase_last      = (cnt_reg == 4'd0);
    assign addr_lsb_unused = ^cpu_addr[1:0];
    assign cpu_rdata       = rdata_reg;
    assign cpu_stall       = cpu_req & ~cpu_ack;

    byte_merge u_merge (
        .old_word    (merge_reg),
        .new_word    (wdata_reg),
        .sel         (sel_reg),
        .merged_word (merged_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        cpu_ack    = 1'b0;
        ram_ce     = RamChipDisable;
        ram_re     = ReadDisable;
        ram_we     = WriteDisable;
        ram_addr   = ZeroWord;
        ram_wdata  = ZeroWord;
        case (state_reg)
            IDLE: begin
                if (cpu_req) begin
                    cnt_next = CntLoad;
                    if (!cpu_we) begin
                        state_next = RD;
                    end else if (cpu_sel == SelAll) begin
                        state_next = WR;
                    end else if (cpu_sel == SelNone) begin
                        state_next = DONE;
                        cnt_next   = 4'd0;
                    end else begin
                        state_next = RMW_RD;
                    end
                end
            end
            RD, RMW_RD: begin
                ram_ce   = RamChipEnable;
                ram_re   = ReadEnable;
                ram_addr = word_addr(word_reg);
                if (!phase_last) begin
                    cnt_next = cnt_reg - 4'd1;
                end else if (state_reg == RMW_RD) begin
                    state_next = RMW_WR;
                    cnt_next   = CntLoad;
                end else begin
                    state_next = DONE;
                end
            end
            WR, RMW_WR: begin
                ram_ce    = RamChipEnable;
                ram_we    = WriteEnable;
                ram_addr  = word_addr(word_reg);
                ram_wdata = (state_reg == RMW_WR) ? merged_word : wdata_reg;
                if (!phase_last) begin
                    cnt_next = cnt_reg - 4'd1;
                end else begin
                    state_next = DONE;
                end
            end
            DONE: begin
                cpu_ack    = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // Request fields are captured once at accept; read data only on a phase's last cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_reg  <= 30'd0;
            sel_reg   <= SelNone;
            wdata_reg <= ZeroWord;
            merge_reg <= ZeroWord;
            rdata_reg <= ZeroWord;
        end else begin
            if (state_reg == IDLE && cpu_req) begin
                word_reg  <= cpu_addr[31:2];
                sel_reg   <= cpu_sel;
                wdata_reg <= cpu_wdata;
            end
            if (state_reg == RD && phase_last) begin
                rdata_reg <= ram_rdata;
            end
            if (state_reg == RMW_RD && phase_last) begin
                merge_reg <= ram_rdata;
            end
        end
    end

endmodule
